cordic_out_framer: RTL and testbench
====================================

Name: cordic_out_framer

Overview:
- Downstream stage of the CORDIC vectoring→rotation chain.
- Consumes the free-running 12-bit re/im sample stream from the rotation stage (valid only, no backpressure).
- Buffers samples in a FIFO and tags each with its in-frame index and an end-of-frame flag.
- Presents samples to a ready/valid consumer (file writer, FFT, DMA), with sticky overflow reporting when that consumer stalls too long.

Parameters:
- DW, 12, width of each real/imag sample.
- DEPTH, 16, FIFO entries; power of 2, ≥2.
- FRAME_LEN, 256, samples per frame; power of 2, ≥2.
- IW, $clog2(FRAME_LEN), in-frame index width (derived).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  sample strobe from rotation stage valid_o.
- in_re  in  DW  signed real sample.
- in_im  in  DW  signed imaginary sample.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_re  out  DW  head real sample.
- out_im  out  DW  head imaginary sample.
- out_idx  out  IW  in-frame index of head sample.
- out_last  out  1  head sample is index FRAME_LEN-1.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- clr_ovf  in  1  clears overflow and drop_cnt.
- overflow  out  1  sticky: at least one sample dropped.
- drop_cnt  out  16  dropped samples, saturating at 0xFFFF.
- frame_cnt  out  16  completed frames popped, wraps modulo 2^16.

Behaviour:
- Reset (rst=0 at a rising edge) has priority over all other activity, including mid-frame and mid-transfer.
  - Pointers, level, in-frame index and frame_cnt go to 0.
  - overflow=0, drop_cnt=0.
  - out_valid=0; out_re, out_im, out_idx, out_last all 0.
  - Buffered data is discarded.
- Push = in_valid && (level<DEPTH || pop). Pop = out_valid && out_ready.
- FIFO is first-word-fall-through.
  - A sample pushed at edge N into an empty FIFO is on out_* with out_valid=1 after edge N (1-cycle latency).
  - out_* are registered; they are held stable while out_valid && !out_ready.
- Full with simultaneous pop: the push is accepted and level stays DEPTH.
- Full without pop, in_valid=1:
  - The sample is dropped and overflow is set.
  - drop_cnt increments (saturating).
  - The in-frame index still advances, so frame alignment follows input time, not stored samples.
- Empty with in_valid: the push occurs and the pop is impossible that cycle (out_valid=0). No bypass.
- In-frame index:
  - Counts every in_valid cycle, 0..FRAME_LEN-1, wrapping to 0.
  - It is stored with the sample. Stored last = (idx==FRAME_LEN-1).
- frame_cnt increments on a pop with out_last=1.
- clr_ovf=1: overflow←0 and drop_cnt←0 next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- level updates: +1 on push only, −1 on pop only, unchanged on both or neither.
- No combinational path from out_ready to any output.

Decomposition:
- Package cordic_pkg holds:
  - DW default.
  - typedef cplx_t (packed struct {logic signed [DW-1:0] re, im}).
  - typedef frame_word_t (cplx_t + idx + last).
- One sub-module, cordic_sync_fifo: generic FWFT FIFO parameterised on word type and DEPTH, with push/pop/full/empty/level.
- Framing, index, drop and frame counting stay in the top.

Test Plan:
- Reset then single sample in_re=12'h123, in_im=12'hF00 with out_ready=1 → next cycle out_valid=1, out_re=0x123, out_im=0xF00, out_idx=0, out_last=0; level returns to 0 after the pop.
- 256 consecutive in_valid with out_ready=1 → outputs in order, idx 0..255, out_last only on idx 255, frame_cnt=1, overflow=0.
- out_ready=0, 20 samples with DEPTH=16 → level=16, overflow=1, drop_cnt=4. Then drain → 16 samples with idx 0..15, and the next input gets idx 20.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle → no drop, level stays 16, head advances by one.
- out_ready toggling 1/0 every cycle with continuous input → out_* stable during stall cycles, and no sample is lost until the level reaches 16.
- Reset mid-frame (idx=100, level=7) → all outputs 0 next cycle. The next sample gets idx 0 and frame_cnt=0.
- clr_ovf asserted in the same cycle as a drop → overflow=1, drop_cnt=1.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC output framer: complex sample and framed FIFO word.
package cordic_pkg;

    localparam int DW        = 12;
    localparam int FRAME_LEN = 256;
    localparam int IW        = $clog2(FRAME_LEN);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        cplx_t         smp;
        logic [IW-1:0] idx;
        logic          last;
    } frame_word_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// Generic first-word-fall-through FIFO; the head word is driven from registers only.
module cordic_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  T                         i_wdata,
    output T                         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           w_pop;
    logic           w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Storage is never cleared, so the head is forced to zero whenever nothing is buffered.
    assign o_rdata = o_empty ? T'('0) : r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/cordic_out_framer.sv
// Frames the free-running rotation-stage sample stream into indexed frames behind a
// FWFT FIFO, with sticky overflow and drop counting when the consumer stalls.
module cordic_out_framer #(
    parameter  int DW        = cordic_pkg::DW,
    parameter  int DEPTH     = 16,
    parameter  int FRAME_LEN = cordic_pkg::FRAME_LEN,
    localparam int IW        = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [DW-1:0]    in_re,
    input  logic signed [DW-1:0]    in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DW-1:0]    out_re,
    output logic signed [DW-1:0]    out_im,
    output logic [IW-1:0]           out_idx,
    output logic                    out_last,
    output logic [$clog2(DEPTH):0]  level,
    input  logic                    clr_ovf,
    output logic                    overflow,
    output logic [15:0]             drop_cnt,
    output logic [15:0]             frame_cnt
);

    import cordic_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    logic [IW-1:0]  r_idx;
    logic           r_overflow;
    logic [15:0]    r_drop_cnt;
    logic [15:0]    r_frame_cnt;

    frame_word_t    w_wr_word;
    frame_word_t    w_head;
    logic           w_full;
    logic           w_empty;
    logic [LW-1:0]  w_level;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;

    assign w_pop  = !w_empty && out_ready;
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    always_comb begin
        w_wr_word        = '0;
        w_wr_word.smp.re = in_re;
        w_wr_word.smp.im = in_im;
        w_wr_word.idx    = r_idx;
        w_wr_word.last   = (r_idx == IW'(FRAME_LEN - 1));
    end

    cordic_sync_fifo #(
        .T     (frame_word_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wr_word),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // The index follows input time, so it advances on dropped samples as well.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx       <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (in_valid) r_idx <= r_idx + IW'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= clr_ovf ? 16'd1 : sat_inc16(r_drop_cnt);
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
            if (w_pop && w_head.last) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign out_valid = !w_empty;
    assign out_re    = w_head.smp.re;
    assign out_im    = w_head.smp.im;
    assign out_idx   = w_head.idx;
    assign out_last  = w_head.last;
    assign level     = w_level;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cordic_out_framer.sv
// Directed/random bench for cordic_out_framer against a queue-based reference model.
module tb_cordic_out_framer;

    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [11:0] in_re = '0;
    logic [11:0] in_im = '0;
    logic        out_valid;
    logic        out_last;
    logic        overflow;
    logic [11:0] out_re;
    logic [11:0] out_im;
    logic [7:0]  out_idx;
    logic [4:0]  level;
    logic [15:0] drop_cnt;
    logic [15:0] frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] re;
        logic [11:0] im;
        int          idx;
    } smp_t;

    smp_t q[$];
    int   m_idx    = 0;
    int   m_drop   = 0;
    int   m_frames = 0;
    bit   m_ovf    = 0;

    cordic_out_framer #(
        .DW        (12),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .level     (level),
        .clr_ovf   (clr_ovf),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [11:0] re, input logic [11:0] im,
                              input logic rdy, input logic clr, input logic rstn);
        bit   pop, push, drop;
        smp_t s;
        if (!rstn) begin
            q.delete();
            m_idx = 0; m_drop = 0; m_frames = 0; m_ovf = 0;
        end else begin
            pop  = (q.size() > 0) && rdy;
            push = v && ((q.size() < DEPTH) || pop);
            drop = v && !push;
            if (pop) begin
                if (q[0].idx == FRAME_LEN - 1) m_frames = (m_frames + 1) % 65536;
                void'(q.pop_front());
            end
            if (push) begin
                s.re = re; s.im = im; s.idx = m_idx;
                q.push_back(s);
            end
            if (v) m_idx = (m_idx + 1) % FRAME_LEN;
            if (drop) begin
                m_ovf  = 1;
                m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
            end else if (clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [11:0] e_re, e_im;
        int          e_idx;
        bit          e_vld;
        e_vld = (q.size() > 0);
        e_re  = e_vld ? q[0].re : 12'h0;
        e_im  = e_vld ? q[0].im : 12'h0;
        e_idx = e_vld ? q[0].idx : 0;
        chk("out_valid", 32'(out_valid), 32'(e_vld));
        chk("out_re",    32'(out_re),    32'(e_re));
        chk("out_im",    32'(out_im),    32'(e_im));
        chk("out_idx",   32'(out_idx),   32'(e_idx));
        chk("out_last",  32'(out_last),  32'(e_vld && (e_idx == FRAME_LEN - 1)));
        chk("level",     32'(level),     32'(q.size()));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    endtask

    task automatic cycle(input logic v, input logic [11:0] re, input logic [11:0] im,
                         input logic rdy, input logic clr, input logic rstn);
        in_valid  = v;
        in_re     = re;
        in_im     = im;
        out_ready = rdy;
        clr_ovf   = clr;
        rst       = rstn;
        model_step(v, re, im, rdy, clr, rstn);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rcycle(input logic v, input logic rdy, input logic clr);
        cycle(v, 12'($urandom), 12'($urandom), rdy, clr, 1'b1);
    endtask

    initial begin
        // Reset state
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);

        // Single sample, 1-cycle latency
        cycle(1, 12'h123, 12'hF00, 1, 0, 1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_re",    32'(out_re),    32'h123);
        chk("t1_im",    32'(out_im),    32'hF00);
        chk("t1_idx",   32'(out_idx),   32'd0);
        chk("t1_last",  32'(out_last),  32'd0);
        cycle(0, 0, 0, 1, 0, 1);
        chk("t1_level", 32'(level), 32'd0);

        // Full frame streaming
        cycle(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 256; i++) rcycle(1, 1, 0);
        for (int i = 0; i < 3; i++) rcycle(0, 1, 0);
        chk("t2_frames", 32'(frame_cnt), 32'd1);
        chk("t2_ovf",    32'(overflow),  32'd0);

        // Overflow with stalled consumer, then drain
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) rcycle(1, 0, 0);
        chk("t3_level", 32'(level),    32'd16);
        chk("t3_ovf",   32'(overflow), 32'd1);
        chk("t3_drop",  32'(drop_cnt), 32'd4);
        for (int i = 0; i < 16; i++) rcycle(0, 1, 0);
        rcycle(1, 1, 0);
        chk("t3_next_idx", 32'(out_idx), 32'd20);

        // Full FIFO with simultaneous push and pop
        rcycle(0, 1, 0);
        for (int i = 0; i < 16; i++) rcycle(1, 0, 0);
        rcycle(1, 1, 0);
        chk("t4_level", 32'(level),    32'd16);
        chk("t4_drop",  32'(drop_cnt), 32'd4);
        chk("t4_head",  32'(out_idx),  32'd22);

        // Toggling ready with continuous input
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 24; i++) rcycle(1, logic'(i % 2 == 0), 0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 24; i++) rcycle(1, logic'(i % 2 == 0), 0);

        // Reset mid-frame
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 93; i++) rcycle(1, 1, 0);
        rcycle(0, 1, 0);
        for (int i = 0; i < 7; i++) rcycle(1, 0, 0);
        chk("t6_level", 32'(level),   32'd7);
        chk("t6_head",  32'(out_idx), 32'd93);
        cycle(1, 12'h5A5, 12'hA5A, 1, 0, 0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_re",    32'(out_re),    32'd0);
        chk("t6_rst_level", 32'(level),     32'd0);
        rcycle(1, 0, 0);
        chk("t6_idx0",   32'(out_idx),   32'd0);
        chk("t6_frames", 32'(frame_cnt), 32'd0);

        // clr_ovf colliding with a drop
        for (int i = 0; i < 15; i++) rcycle(1, 0, 0);
        for (int i = 0; i < 3; i++) rcycle(1, 0, 0);
        chk("t7_drop3", 32'(drop_cnt), 32'd3);
        rcycle(1, 0, 1);
        chk("t7_ovf",  32'(overflow), 32'd1);
        chk("t7_drop", 32'(drop_cnt), 32'd1);
        rcycle(0, 0, 1);
        chk("t7_clr_ovf",  32'(overflow), 32'd0);
        chk("t7_clr_drop", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 20; i++) rcycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
